if_id_stage: RTL and testbench



---
 rtl/if_id_stage_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/if_id_stage.sv | 92 +++++++++
 tb/tb_if_id_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared widths, instruction field positions and NOP encoding
//   Imported by if_id_stage and sat_counter users; no ports.
package if_id_stage_pkg;

  localparam int INST_W = 16;
  localparam int ADDR_W = 16;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 3;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM6_HI  = 5;
  localparam int IMM6_LO  = 0;
  localparam int JADDR_HI = 11;
  localparam int JADDR_LO = 0;

  localparam logic [INST_W-1:0] NOP_ENC = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//   clk   : rising-edge clock
//   clear : synchronous clear, wins over en
//   en    : increment request, ignored once the count is all-ones
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with early decode and perf counters
//   clk, rst              : clock, synchronous active-high reset
//   stall, flush          : hold ID contents / replace them with a bubble (flush wins)
//   if_pc, if_next_pc     : fetch-stage PC and PC+2
//   if_instruction        : fetched instruction word
//   id_valid/pc/next_pc/instruction : registered ID contents
//   id_opcode/rs/rt/rd/funct/imm_sext : decode of the registered instruction
//   id_branch_target, id_jump_target  : targets fed back to fetch
//   perf_issued, perf_bubbles         : saturating performance counters
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_ENC,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [ADDR_W-1:0] if_next_pc,
  input  logic [INST_W-1:0] if_instruction,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_next_pc,
  output logic [INST_W-1:0] id_instruction,
  output logic [3:0]        id_opcode,
  output logic [2:0]        id_rs,
  output logic [2:0]        id_rt,
  output logic [2:0]        id_rd,
  output logic [2:0]        id_funct,
  output logic [ADDR_W-1:0] id_imm_sext,
  output logic [ADDR_W-1:0] id_branch_target,
  output logic [ADDR_W-1:0] id_jump_target,
  output logic [CNT_W-1:0]  perf_issued,
  output logic [CNT_W-1:0]  perf_bubbles
);

  logic issue_en;
  logic bubble_en;

  // A flush still captures the fetch PC so traces of the bubble show where it came from.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_next_pc     <= '0;
      id_instruction <= NOP_INST;
    end else if (flush) begin
      id_valid       <= 1'b0;
      id_pc          <= if_pc;
      id_next_pc     <= if_next_pc;
      id_instruction <= NOP_INST;
    end else if (!stall) begin
      id_valid       <= 1'b1;
      id_pc          <= if_pc;
      id_next_pc     <= if_next_pc;
      id_instruction <= if_instruction;
    end
  end

  assign issue_en  = !flush && !stall;
  assign bubble_en = flush;

  sat_counter #(.W(CNT_W)) u_issued_cnt (
    .clk   (clk),
    .clear (rst),
    .en    (issue_en),
    .count (perf_issued)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .en    (bubble_en),
    .count (perf_bubbles)
  );

  assign id_opcode   = id_instruction[OPC_HI:OPC_LO];
  assign id_rs       = id_instruction[RS_HI:RS_LO];
  assign id_rt       = id_instruction[RT_HI:RT_LO];
  assign id_rd       = id_instruction[RD_HI:RD_LO];
  assign id_funct    = id_instruction[FUNCT_HI:FUNCT_LO];
  assign id_imm_sext = {{(ADDR_W-(IMM6_HI-IMM6_LO+1)){id_instruction[IMM6_HI]}},
                        id_instruction[IMM6_HI:IMM6_LO]};

  // Offsets are in halfwords; the top bit of the shifted immediate falls off, matching mod-2^16 wrap.
  assign id_branch_target = id_next_pc + {id_imm_sext[ADDR_W-2:0], 1'b0};
  assign id_jump_target   = {id_next_pc[ADDR_W-1:JADDR_HI+2],
                             id_instruction[JADDR_HI:JADDR_LO], 1'b0};

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [15:0] if_pc, if_next_pc, if_instruction;

  logic        id_valid;
  logic [15:0] id_pc, id_next_pc, id_instruction;
  logic [3:0]  id_opcode;
  logic [2:0]  id_rs, id_rt, id_rd, id_funct;
  logic [15:0] id_imm_sext, id_branch_target, id_jump_target;
  logic [15:0] perf_issued, perf_bubbles;

  logic        s_valid;
  logic [15:0] s_pc, s_next_pc, s_instruction;
  logic [3:0]  s_opcode;
  logic [2:0]  s_rs, s_rt, s_rd, s_funct;
  logic [15:0] s_imm_sext, s_branch_target, s_jump_target;
  logic [3:0]  s_issued, s_bubbles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_next_pc(if_next_pc), .if_instruction(if_instruction),
    .id_valid(id_valid), .id_pc(id_pc), .id_next_pc(id_next_pc),
    .id_instruction(id_instruction), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_imm_sext(id_imm_sext),
    .id_branch_target(id_branch_target), .id_jump_target(id_jump_target),
    .perf_issued(perf_issued), .perf_bubbles(perf_bubbles)
  );

  if_id_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_next_pc(if_next_pc), .if_instruction(if_instruction),
    .id_valid(s_valid), .id_pc(s_pc), .id_next_pc(s_next_pc),
    .id_instruction(s_instruction), .id_opcode(s_opcode), .id_rs(s_rs),
    .id_rt(s_rt), .id_rd(s_rd), .id_funct(s_funct), .id_imm_sext(s_imm_sext),
    .id_branch_target(s_branch_target), .id_jump_target(s_jump_target),
    .perf_issued(s_issued), .perf_bubbles(s_bubbles)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic [15:0] pc, npc, inst;
    logic        e_valid;
    logic [15:0] e_pc, e_npc, e_inst, e_iss, e_bub;
  } vec_t;

  typedef struct {
    int          idx;
    logic        valid;
    logic [15:0] pc, npc, inst, iss, bub;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic s, logic f, logic [15:0] pc, logic [15:0] inst,
                              logic ev, logic [15:0] epc, logic [15:0] einst,
                              logic [15:0] eiss, logic [15:0] ebub);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f;
    v.pc = pc; v.npc = pc + 16'd2; v.inst = inst;
    v.e_valid = ev; v.e_pc = epc; v.e_npc = (r || epc == 16'h0 && !ev && einst == 16'h0 && eiss == 0) ? 16'h0 : epc + 16'd2;
    v.e_inst = einst; v.e_iss = eiss; v.e_bub = ebub;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Independent reference decode of the expected ID contents.
  task automatic compare(exp_t e);
    int          imm;
    logic [15:0] sext, bt, jt;
    imm = int'(e.inst & 16'h003F);
    if (imm >= 32) imm = imm - 64;
    sext = 16'(imm);
    bt   = 16'(int'(e.npc) + imm * 2);
    jt   = (e.npc & 16'hE000) | 16'((int'(e.inst) & 32'h0FFF) * 2);
    chk("valid",   e.idx, {15'h0, id_valid}, {15'h0, e.valid});
    chk("pc",      e.idx, id_pc, e.pc);
    chk("next_pc", e.idx, id_next_pc, e.npc);
    chk("inst",    e.idx, id_instruction, e.inst);
    chk("opcode",  e.idx, {12'h0, id_opcode}, e.inst / 16'd4096);
    chk("rs",      e.idx, {13'h0, id_rs}, (e.inst / 16'd512) % 16'd8);
    chk("rt",      e.idx, {13'h0, id_rt}, (e.inst / 16'd64) % 16'd8);
    chk("rd",      e.idx, {13'h0, id_rd}, (e.inst / 16'd8) % 16'd8);
    chk("funct",   e.idx, {13'h0, id_funct}, e.inst % 16'd8);
    chk("sext",    e.idx, id_imm_sext, sext);
    chk("btarget", e.idx, id_branch_target, bt);
    chk("jtarget", e.idx, id_jump_target, jt);
    chk("issued",  e.idx, perf_issued, e.iss);
    chk("bubbles", e.idx, perf_bubbles, e.bub);
  endtask

  task automatic drive(logic r, logic s, logic f, logic [15:0] pc, logic [15:0] inst);
    rst = r; stall = s; flush = f;
    if_pc = pc; if_next_pc = pc + 16'd2; if_instruction = inst;
  endtask

  initial begin
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);

    //           rst  stl  fls  pc       inst      ev   epc      einst     iss  bub
    vecs.push_back(mk(1, 0, 0, 16'h1234, 16'h5678, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h1234, 16'h5678, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0010, 16'h1A47, 1, 16'h0010, 16'h1A47, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0020, 16'h703C, 1, 16'h0020, 16'h703C, 2, 0));
    vecs.push_back(mk(0, 0, 0, 16'hFFFC, 16'h0001, 1, 16'hFFFC, 16'h0001, 3, 0));
    vecs.push_back(mk(0, 0, 0, 16'hA000, 16'h2ABC, 1, 16'hA000, 16'h2ABC, 4, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0100, 16'h0020, 1, 16'h0100, 16'h0020, 5, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0200, 16'h1111, 1, 16'h0200, 16'h1111, 6, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0300, 16'h2222, 1, 16'h0200, 16'h1111, 6, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0300, 16'h2222, 1, 16'h0200, 16'h1111, 6, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0300, 16'h2222, 1, 16'h0200, 16'h1111, 6, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0300, 16'h2222, 1, 16'h0300, 16'h2222, 7, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0400, 16'h3333, 0, 16'h0400, 16'h0000, 7, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0500, 16'h4444, 0, 16'h0500, 16'h0000, 7, 2));
    vecs.push_back(mk(0, 1, 0, 16'h0600, 16'h5555, 0, 16'h0500, 16'h0000, 7, 2));
    vecs.push_back(mk(0, 0, 0, 16'h0600, 16'h5555, 1, 16'h0600, 16'h5555, 8, 2));
    vecs.push_back(mk(0, 1, 0, 16'h0700, 16'h6666, 1, 16'h0600, 16'h5555, 8, 2));
    vecs.push_back(mk(1, 1, 0, 16'h0700, 16'h6666, 0, 16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0700, 16'h6666, 1, 16'h0700, 16'h6666, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].pc, vecs[i].inst);
      e.idx = i; e.valid = vecs[i].e_valid; e.pc = vecs[i].e_pc; e.npc = vecs[i].e_npc;
      e.inst = vecs[i].e_inst; e.iss = vecs[i].e_iss; e.bub = vecs[i].e_bub;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
      end else begin
        compare(sb.pop_front());
      end
    end

    // Literal targets from hand arithmetic, independent of the reference decode.
    drive(0, 0, 0, 16'h0020, 16'h003C); @(posedge clk); #1;
    chk("sext_m4",  100, id_imm_sext, 16'hFFFC);
    chk("bt_m4",    100, id_branch_target, 16'h001A);
    drive(0, 0, 0, 16'hFFFC, 16'h0001); @(posedge clk); #1;
    chk("bt_wrap",  101, id_branch_target, 16'h0000);
    drive(0, 0, 0, 16'hA000, 16'h2ABC); @(posedge clk); #1;
    chk("jt",       102, id_jump_target, 16'hB578);
    drive(0, 0, 0, 16'h0100, 16'h0020); @(posedge clk); #1;
    chk("sext_min", 103, id_imm_sext, 16'hFFE0);
    chk("bt_min",   103, id_branch_target, 16'h00C2);

    // Saturation: 20 loads then 17 flushes on both counter widths.
    drive(1, 0, 0, 16'h0000, 16'h0000); @(posedge clk); #1;
    chk("sat_rst", 200, {12'h0, s_issued}, 16'h0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 16'(k * 2), 16'(k)); @(posedge clk); #1;
      chk("iss16", 200 + k, perf_issued, 16'(k));
      chk("iss4",  200 + k, {12'h0, s_issued}, (k > 15) ? 16'hF : 16'(k));
    end
    for (int k = 1; k <= 17; k++) begin
      drive(0, 0, 1, 16'h0040, 16'h7777); @(posedge clk); #1;
      chk("bub4",  300 + k, {12'h0, s_bubbles}, (k > 15) ? 16'hF : 16'(k));
      chk("bvalid", 300 + k, {15'h0, s_valid}, 16'h0);
    end
    chk("iss4_hold", 400, {12'h0, s_issued}, 16'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
